// File: rtl/rf_multiport.sv
// Multiport register file: NUM_RD combinational reads, two prioritised write ports,
// per-register busy scoreboard and registered probe. Optional write bypass: RF_BYPASS_EN.
module rf_multiport #(
   parameter int DW        = 32,
   parameter int DEPTH     = 32,
   parameter int AW        = $clog2(DEPTH),
   parameter int NUM_RD    = 2,
   parameter int PROBE_IDX = 19
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_RD*AW-1:0] rd_addr,
   output logic [NUM_RD*DW-1:0] rd_data,
   output logic [NUM_RD-1:0]    rd_busy,
   input  logic [1:0]           wr_en,
   input  logic [2*AW-1:0]      wr_addr,
   input  logic [2*DW-1:0]      wr_data,
   input  logic                 bs_en,
   input  logic [AW-1:0]        bs_addr,
   output logic [DEPTH-1:0]     busy_vec,
   output logic [DW-1:0]        probe_data
);

   logic [DW-1:0]    regs     [DEPTH];
   logic [DW-1:0]    reg_next [DEPTH];
   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_next;

   logic [AW-1:0] wa0, wa1;
   logic [DW-1:0] wd0, wd1;

   assign wa0 = wr_addr[0 +: AW];
   assign wa1 = wr_addr[AW +: AW];
   assign wd0 = wr_data[0 +: DW];
   assign wd1 = wr_data[DW +: DW];

   // Register 0 is pinned to zero/idle, so entry 0 is never updated.
   always_comb begin
      busy_next = busy;
      for (int unsigned r = 0; r < DEPTH; r++) begin
         reg_next[r] = regs[r];
      end
      for (int unsigned r = 1; r < DEPTH; r++) begin
         if (wr_en[1] && wa1 == AW'(r)) begin
            reg_next[r] = wd1;
         end else if (wr_en[0] && wa0 == AW'(r)) begin
            reg_next[r] = wd0;
         end
         if (bs_en && bs_addr == AW'(r)) begin
            busy_next[r] = 1'b1;
         end else if ((wr_en[1] && wa1 == AW'(r)) || (wr_en[0] && wa0 == AW'(r))) begin
            busy_next[r] = 1'b0;
         end
      end
      reg_next[0]  = '0;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned r = 0; r < DEPTH; r++) begin
            regs[r] <= '0;
         end
         busy       <= '0;
         probe_data <= '0;
      end else begin
         for (int unsigned r = 0; r < DEPTH; r++) begin
            regs[r] <= reg_next[r];
         end
         busy       <= busy_next;
         // Probe samples the post-write value so it trails writes by one edge.
         probe_data <= reg_next[PROBE_IDX];
      end
   end

   assign busy_vec = busy;

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int unsigned i = 0; i < NUM_RD; i++) begin
         logic [AW-1:0] a;
         logic [DW-1:0] d;
         logic          b;
         a = rd_addr[i*AW +: AW];
         d = regs[a];
         b = busy[a];
`ifdef RF_BYPASS_EN
         if (a != '0) begin
            if ((wr_en[1] && wa1 == a) || (wr_en[0] && wa0 == a)) begin
               d = (wr_en[1] && wa1 == a) ? wd1 : wd0;
               if (!(bs_en && bs_addr == a)) begin
                  b = 1'b0;
               end
            end
         end
`endif
         rd_data[i*DW +: DW] = d;
         rd_busy[i]          = b;
      end
   end

endmodule

// File: tb/tb_rf_multiport.sv
// Scoreboard bench for rf_multiport: stimulus queues expected outputs tagged with
// the cycle they apply to; a negedge monitor pops and compares them.
module tb_rf_multiport;

   localparam int DW     = 32;
   localparam int DEPTH  = 32;
   localparam int AW     = 5;
   localparam int NUM_RD = 2;

   localparam int W_RD0 = 0, W_RD1 = 1, W_BZ0 = 10, W_BZ1 = 11, W_BVEC = 20, W_PROBE = 21;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NUM_RD*AW-1:0] rd_addr;
   logic [NUM_RD*DW-1:0] rd_data;
   logic [NUM_RD-1:0]    rd_busy;
   logic [1:0]           wr_en;
   logic [2*AW-1:0]      wr_addr;
   logic [2*DW-1:0]      wr_data;
   logic                 bs_en;
   logic [AW-1:0]        bs_addr;
   logic [DEPTH-1:0]     busy_vec;
   logic [DW-1:0]        probe_data;

   rf_multiport #(.DW(DW), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .PROBE_IDX(19)) dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .bs_en(bs_en),
      .bs_addr(bs_addr), .busy_vec(busy_vec), .probe_data(probe_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      int          w;
      logic [63:0] exp;
      string       nm;
   } exp_t;

   exp_t q[$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] get_out(input int w);
      case (w)
         W_RD0:   return 64'(rd_data[0 +: DW]);
         W_RD1:   return 64'(rd_data[DW +: DW]);
         W_BZ0:   return 64'(rd_busy[0]);
         W_BZ1:   return 64'(rd_busy[1]);
         W_BVEC:  return 64'(busy_vec);
         W_PROBE: return 64'(probe_data);
         default: return '1;
      endcase
   endfunction

   always @(negedge clk) begin
      int i;
      i = 0;
      while (i < q.size()) begin
         if (q[i].cyc <= cyc) begin
            logic [63:0] act;
            act = get_out(q[i].w);
            total++;
            if (q[i].cyc < cyc) begin
               bad++;
               $display("FAIL %s: stale check for cycle %0d at cycle %0d", q[i].nm, q[i].cyc, cyc);
            end else if (act !== q[i].exp) begin
               bad++;
               $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", q[i].nm, cyc, act, q[i].exp);
            end
            q.delete(i);
         end else begin
            i++;
         end
      end
   end

   task automatic push_now(input int w, input logic [63:0] e, input string nm);
      exp_t x;
      x.cyc = cyc; x.w = w; x.exp = e; x.nm = nm;
      q.push_back(x);
   endtask

   task automatic push_next(input int w, input logic [63:0] e, input string nm);
      exp_t x;
      x.cyc = cyc + 1; x.w = w; x.exp = e; x.nm = nm;
      q.push_back(x);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      wr_en = '0; bs_en = 1'b0;
   endtask

   task automatic wr(input int p, input int a, input logic [DW-1:0] d);
      wr_en[p]            = 1'b1;
      wr_addr[p*AW +: AW] = AW'(a);
      wr_data[p*DW +: DW] = d;
   endtask

   task automatic rd(input int a0, input int a1);
      rd_addr = {AW'(a1), AW'(a0)};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] old12;
      rst = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
      bs_en = 1'b0; bs_addr = '0;
      tick; tick;
      rst = 1'b0;

      // Post-reset sweep of every address on both ports.
      push_now(W_BVEC, 64'd0, "reset_busy_vec");
      push_now(W_PROBE, 64'd0, "reset_probe");
      for (int a = 0; a < DEPTH; a++) begin
         rd(a, DEPTH - 1 - a);
         push_now(W_RD0, 64'd0, "reset_rd0");
         push_now(W_RD1, 64'd0, "reset_rd1");
         push_now(W_BZ0, 64'd0, "reset_busy0");
         push_now(W_BZ1, 64'd0, "reset_busy1");
         tick;
      end

      wr(0, 5, 32'hDEADBEEF); tick; idle;
      rd(5, 0);
      push_now(W_RD0, 64'hDEADBEEF, "write_reg5");
      push_now(W_RD1, 64'd0, "reg0_read");
      tick;

      wr(0, 0, 32'h1234); wr(1, 0, 32'h5678); tick; idle;
      rd(0, 5);
      push_now(W_RD0, 64'd0, "reg0_write_ignored");
      push_now(W_RD1, 64'hDEADBEEF, "reg5_kept");
      tick;

      wr(0, 7, 32'h11); wr(1, 7, 32'h22); tick; idle;
      rd(7, 7);
      push_now(W_RD0, 64'h22, "same_addr_port1_wins");
      tick;

      wr(0, 3, 32'hA); wr(1, 4, 32'hB); tick; idle;
      rd(3, 4);
      push_now(W_RD0, 64'hA, "dual_write_reg3");
      push_now(W_RD1, 64'hB, "dual_write_reg4");
      tick;

      bs_en = 1'b1; bs_addr = 9; tick; idle;
      rd(9, 0);
      push_now(W_BVEC, 64'h200, "busy_set9");
      push_now(W_BZ0, 64'd1, "rd_busy9");
      push_now(W_BZ1, 64'd0, "rd_busy_reg0");
      tick;

      bs_en = 1'b1; bs_addr = 9; wr(0, 9, 32'h99); tick; idle;
      push_now(W_BVEC, 64'h200, "set_and_clear_keeps_busy");
      push_now(W_RD0, 64'h99, "write_reg9");
      tick;

      bs_en = 1'b1; bs_addr = 9; tick; idle;
      push_now(W_BVEC, 64'h200, "reset_busy_no_count");
      tick;

      wr(1, 9, 32'h98); tick; idle;
      push_now(W_BVEC, 64'd0, "busy_clear9");
      push_now(W_BZ0, 64'd0, "rd_busy9_clear");
      push_now(W_RD0, 64'h98, "write_reg9_p1");
      tick;

      bs_en = 1'b1; bs_addr = 0; tick; idle;
      rd(0, 0);
      push_now(W_BVEC, 64'd0, "busy_set_reg0_ignored");
      push_now(W_BZ0, 64'd0, "rd_busy_reg0_after_set");
      tick;

      // Same-cycle write/read of reg 12 while it is busy.
      old12 = 32'h77;
      wr(0, 12, old12); tick; idle;
      bs_en = 1'b1; bs_addr = 12; tick; idle;
      rd(0, 12);
      push_now(W_BZ1, 64'd1, "busy12_before");
      tick;
      wr(0, 12, 32'hCAFE);
      rd(0, 12);
`ifdef RF_BYPASS_EN
      push_now(W_RD1, 64'hCAFE, "bypass_data");
      push_now(W_BZ1, 64'd0, "bypass_busy");
`else
      push_now(W_RD1, 64'(old12), "no_bypass_old_data");
      push_now(W_BZ1, 64'd1, "no_bypass_busy");
`endif
      tick; idle;
      push_now(W_RD1, 64'hCAFE, "write12_visible");
      push_now(W_BZ1, 64'd0, "busy12_cleared");
      tick;

      wr(0, 19, 32'h55);
      push_now(W_PROBE, 64'd0, "probe_before_write");
      push_next(W_PROBE, 64'h55, "probe_after_write");
      tick; idle;
      tick;

      bs_en = 1'b1; bs_addr = 3; tick;
      bs_addr = 5; tick; idle;
      push_now(W_BVEC, 64'h28, "busy_before_reset");
      tick;
      rst = 1'b1; wr(0, 6, 32'h66); wr(1, 19, 32'h77); bs_en = 1'b1; bs_addr = 8;
      tick;
      rst = 1'b0; idle;
      rd(19, 6);
      push_now(W_BVEC, 64'd0, "reset_clears_busy");
      push_now(W_PROBE, 64'd0, "reset_clears_probe");
      push_now(W_RD0, 64'd0, "reset_overrides_write19");
      push_now(W_RD1, 64'd0, "reset_overrides_write6");
      tick;
      rd(5, 7);
      push_now(W_RD0, 64'd0, "reset_clears_reg5");
      push_now(W_RD1, 64'd0, "reset_clears_reg7");
      tick;

      tick; tick;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
- Parametrised successor to the single-write, two-read register file.
- Provides configurable width, depth and read-port count, plus two write ports (ALU writeback and load writeback).
- Holds a per-register busy scoreboard for pipeline hazard detection and a configurable debug probe register.
- Sits between decode (reads, busy set) and writeback (writes, busy clear) in the pipelined core.

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of architectural registers; power of two, at least 2.
- AW, $clog2(DEPTH), register address width (derived).
- NUM_RD, 2, number of read ports, 1..4.
- PROBE_IDX, 19, register index driven onto probe_data.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rd_addr  in  NUM_RD*AW  read addresses; port i uses bits [i*AW +: AW].
- rd_data  out  NUM_RD*DW  read data; port i uses bits [i*DW +: DW].
- rd_busy  out  NUM_RD  scoreboard busy flag for each read address.
- wr_en  in  2  write enables; port 1 has priority over port 0.
- wr_addr  in  2*AW  write addresses.
- wr_data  in  2*DW  write data.
- bs_en  in  1  busy set: marks bs_addr as having a pending producer.
- bs_addr  in  AW  busy set address.
- busy_vec  out  DEPTH  full scoreboard, for stall logic and debug.
- probe_data  out  DW  registered copy of reg[PROBE_IDX].

Behaviour:
- Reset (rst high at posedge clk):
  - all registers := 0; all busy bits := 0; probe_data := 0.
  - Reset overrides any same-cycle write or busy set.
  - A reset asserted mid-operation discards pending scoreboard state.
- Register 0:
  - reads always return 0; rd_busy is always 0 for address 0.
  - writes and busy sets to address 0 are ignored; busy_vec[0] is always 0.
- Reads: combinational, zero latency. rd_data[i] = reg[rd_addr[i]] (subject to the bypass rule in Optional Feature).
- Writes: take effect at posedge clk when wr_en[k]=1 and wr_addr[k]!=0.
  - Both ports writing the same address: port 1 data is stored; port 0 is dropped.
  - Distinct addresses: both are written in the same cycle.
- Scoreboard, per register r, updated at posedge:
  - set if bs_en=1 and bs_addr==r;
  - else cleared if any wr_en[k]=1 with wr_addr[k]==r;
  - else held.
  - A set and a clear of the same register in one cycle leaves it busy (new producer wins).
  - Busy set to a register that is already busy keeps it busy (no counting).
- rd_busy[i] = busy[rd_addr[i]] with the bypass adjustment described below.
- probe_data: registered; updated each cycle to the value of reg[PROBE_IDX] after that edge's write, so it reflects writes with 1-cycle latency.
- Out-of-range addresses cannot occur because DEPTH = 2^AW.
- No X propagation: every register has a defined reset value.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - If any wr_en[k] targets rd_addr[i] (nonzero) in the current cycle, rd_data[i] returns that write's data (port 1 over port 0) combinationally.
  - rd_busy[i] is forced to 0 in that case, unless bs_en targets the same address this cycle.
- Undefined:
  - rd_data returns the stored value; newly written data is visible the cycle after the write.
  - rd_busy reflects the stored busy bit only.

Test Plan:
- Reset then read all addresses on every port -> all rd_data=0, busy_vec=0, probe_data=0.
- wr_en=2'b01, wr_addr0=5, wr_data0=0xDEADBEEF; next cycle rd_addr0=5 -> rd_data0=0xDEADBEEF. Write 0x1234 to reg 0 -> reads of reg 0 still return 0.
- Both ports write addr 7 (port0=0x11, port1=0x22) -> reg7=0x22. Distinct addrs 3/4 written in the same cycle -> both updated.
- bs_en=1, bs_addr=9 -> busy_vec[9]=1 next cycle. Same cycle as a write to 9 -> stays busy. Write to 9 alone -> busy clears next cycle.
- With RF_BYPASS_EN: write 0xCAFE to reg 12 while rd_addr1=12 in the same cycle -> rd_data1=0xCAFE and rd_busy[1]=0 in that cycle. Without the macro -> old value in that cycle, 0xCAFE one cycle later.
- Write 0x55 to reg PROBE_IDX=19 -> probe_data=0x55 one cycle after the write edge. rst asserted with busy bits set and concurrent writes -> all state zero after the edge.
